// File: rtl/usbfs_endp_rx.sv
// USB full-speed OUT endpoint: drains one received packet from the u_rx buffer
// and streams it to the application as valid/ready bytes, NAKing the host meanwhile.
module usbfs_endp_rx #(
  parameter  int unsigned MAX_PKT  = 8,
  localparam int unsigned IDX_W    = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1,
  localparam int unsigned NBYTES_W = $clog2(MAX_PKT + 1)
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_erValid,
  output logic                o_erReady,
  output logic                o_erStall,
  input  logic [NBYTES_W-1:0] i_erRxNBytes,
  output logic                o_erRdEn,
  output logic [IDX_W-1:0]    o_erRdIdx,
  input  logic [7:0]          i_erRdByte,
  output logic                o_valid,
  output logic [7:0]          o_data,
  output logic                o_last,
  input  logic                i_ready
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_PRESENT
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    rdidx_q, rdidx_d;
  logic [NBYTES_W-1:0] nbytes_q, nbytes_d;
  logic [7:0]          data_q, data_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                rden_q, rden_d;
  logic                erready_q, erready_d;
  logic                is_last_c;

  // Current byte is the final one of the packet.
  assign is_last_c = (NBYTES_W'(rdidx_q) == (nbytes_q - NBYTES_W'(1)));

  // Next-state logic; outputs are registered from the next-state values.
  always_comb begin
    state_d  = state_q;
    rdidx_d  = rdidx_q;
    nbytes_d = nbytes_q;
    data_d   = data_q;

    case (state_q)
      ST_IDLE: begin
        // Zero-length packets are consumed without leaving IDLE.
        if (i_erValid && (i_erRxNBytes != '0)) begin
          nbytes_d = i_erRxNBytes;
          rdidx_d  = '0;
          state_d  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        data_d  = i_erRdByte;
        state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (i_ready) begin
          if (is_last_c) begin
            state_d = ST_IDLE;
          end else begin
            rdidx_d = rdidx_q + IDX_W'(1);
            state_d = ST_FETCH;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    valid_d   = (state_d == ST_PRESENT);
    last_d    = valid_d && (NBYTES_W'(rdidx_d) == (nbytes_d - NBYTES_W'(1)));
    rden_d    = (state_d == ST_FETCH);
    erready_d = (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q   <= ST_IDLE;
      rdidx_q   <= '0;
      nbytes_q  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      rden_q    <= 1'b0;
      erready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      rdidx_q   <= rdidx_d;
      nbytes_q  <= nbytes_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      rden_q    <= rden_d;
      erready_q <= erready_d;
    end
  end

  assign o_erReady = erready_q;
  assign o_erStall = 1'b0;
  assign o_erRdEn  = rden_q;
  assign o_erRdIdx = rdidx_q;
  assign o_valid   = valid_q;
  assign o_data    = data_q;
  assign o_last    = last_q;

  // Protocol checks; a packet strobe while busy is tolerated and only reported.
  a_data_stable: assert property (@(posedge i_clk) disable iff (!i_rstn)
    (o_valid && !i_ready) |=> (o_valid && $stable(o_data)))
    else $error("usbfs_endp_rx: o_data changed while stalled");

  a_rden_fetch: assert property (@(posedge i_clk) disable iff (!i_rstn)
    o_erRdEn |-> (state_q == ST_FETCH))
    else $error("usbfs_endp_rx: read request outside FETCH");

  a_last_valid: assert property (@(posedge i_clk) disable iff (!i_rstn)
    o_last |-> o_valid)
    else $error("usbfs_endp_rx: o_last without o_valid");

  a_nbytes_legal: assert property (@(posedge i_clk) disable iff (!i_rstn)
    (i_erValid && (state_q == ST_IDLE)) |-> (i_erRxNBytes <= NBYTES_W'(MAX_PKT)))
    else $error("usbfs_endp_rx: packet length above MAX_PKT");

  a_valid_in_idle: assert property (@(posedge i_clk) disable iff (!i_rstn)
    i_erValid |-> (state_q == ST_IDLE))
    else $warning("usbfs_endp_rx: i_erValid while a packet is pending, ignored");

endmodule
